// File: rtl/axicb_pkg.sv
// rtl/axicb_pkg.sv - shared types and helpers for the crossbar slave write mux
package axicb_pkg;

  // Largest master count the index helpers are sized for.
  localparam int unsigned MAX_REQ_NB = 4;
  localparam int unsigned MAX_IDX_W  = $clog2(MAX_REQ_NB);

  typedef enum logic [0:0] {
    AW_IDLE    = 1'b0,
    AW_GRANTED = 1'b1
  } aw_state_e;

  // Index width for n masters; a single master still needs one bit of storage.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot to binary index; OR-reduction keeps it a flat mux-free encoder.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ_NB-1:0] onehot);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_REQ_NB; k++) begin
      if (onehot[k]) begin
        idx = idx | MAX_IDX_W'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/axicb_order_fifo.sv
// rtl/axicb_order_fifo.sv - small synchronous FIFO holding the AW-granted master order
module axicb_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Entry storage; contents are don't-care until the count covers them, so no reset.
  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge aclk) begin
    if (!aresetn || srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axicb_slv_wr_mux.sv
// rtl/axicb_slv_wr_mux.sv - slave-port write mux: AW arbitration handoff and AW-ordered W routing
module axicb_slv_wr_mux
  import axicb_pkg::*;
#(
  parameter int REQ_NB      = 4,
  parameter int AWCH_W      = 64,
  parameter int WCH_W       = 72,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  output logic                     arb_en,
  output logic [REQ_NB-1:0]        arb_req,
  input  logic [REQ_NB-1:0]        arb_grant,
  input  logic [REQ_NB-1:0]        i_awvalid,
  output logic [REQ_NB-1:0]        i_awready,
  input  logic [REQ_NB*AWCH_W-1:0] i_awch,
  input  logic [REQ_NB-1:0]        i_wvalid,
  output logic [REQ_NB-1:0]        i_wready,
  input  logic [REQ_NB-1:0]        i_wlast,
  input  logic [REQ_NB*WCH_W-1:0]  i_wch,
  output logic                     o_awvalid,
  input  logic                     o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  output logic                     o_wvalid,
  input  logic                     o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch
);

  localparam int IDX_W = idx_width(REQ_NB);

  aw_state_e             state_q;
  logic [IDX_W-1:0]      aw_sel_q;
  logic                  rst_act;
  logic                  aw_decide;
  logic                  aw_hs;
  logic [MAX_REQ_NB-1:0] grant_ext;
  logic [MAX_IDX_W-1:0]  grant_idx_full;
  logic [IDX_W-1:0]      grant_idx;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [IDX_W-1:0]      w_sel;

  // While reset is held the port must look quiet, so every handshake output is gated.
  assign rst_act = !aresetn || srst;
  assign arb_req = i_awvalid;

  assign grant_ext      = MAX_REQ_NB'(arb_grant);
  assign grant_idx_full = onehot_to_idx(grant_ext);
  assign grant_idx      = grant_idx_full[IDX_W-1:0];

  // Decision uses only registered state plus requests/grant, never o_awready.
  assign aw_decide = !rst_act && (state_q == AW_IDLE) && (|i_awvalid) &&
                     !fifo_full && (|arb_grant);
  assign arb_en    = aw_decide;

  assign aw_hs    = o_awvalid && o_awready;
  assign fifo_pop = o_wvalid && o_wready && o_wlast;

  // AW FSM: latch the granted master, hold it until its AW is accepted downstream.
  always_ff @(posedge aclk) begin
    if (rst_act) begin
      state_q  <= AW_IDLE;
      aw_sel_q <= '0;
    end else begin
      case (state_q)
        AW_IDLE: begin
          if (aw_decide) begin
            aw_sel_q <= grant_idx;
            state_q  <= AW_GRANTED;
          end
        end
        AW_GRANTED: begin
          if (aw_hs) begin
            state_q <= AW_IDLE;
          end
        end
      endcase
    end
  end

  // AW path: only the latched master is connected to the slave while GRANTED.
  always_comb begin
    o_awvalid = 1'b0;
    o_awch    = '0;
    i_awready = '0;
    if (!rst_act && (state_q == AW_GRANTED)) begin
      for (int k = 0; k < REQ_NB; k++) begin
        if (aw_sel_q == IDX_W'(k)) begin
          o_awvalid    = i_awvalid[k];
          o_awch       = i_awch[k*AWCH_W +: AWCH_W];
          i_awready[k] = o_awready;
        end
      end
    end
  end

  // W path: the oldest accepted AW owns the W channel until its last beat.
  always_comb begin
    o_wvalid = 1'b0;
    o_wlast  = 1'b0;
    o_wch    = '0;
    i_wready = '0;
    if (!rst_act && !fifo_empty) begin
      for (int k = 0; k < REQ_NB; k++) begin
        if (w_sel == IDX_W'(k)) begin
          o_wvalid    = i_wvalid[k];
          o_wlast     = i_wlast[k];
          o_wch       = i_wch[k*WCH_W +: WCH_W];
          i_wready[k] = o_wready;
        end
      end
    end
  end

  axicb_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (IDX_W)
  ) u_order_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .push      (aw_hs),
    .push_data (aw_sel_q),
    .pop       (fifo_pop),
    .pop_data  (w_sel),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_axicb_slv_wr_mux.sv
// tb/tb_axicb_slv_wr_mux.sv - table, scenario and randomized checks for the slave write mux
module tb_axicb_slv_wr_mux;

  localparam int N     = 4;
  localparam int AW    = 64;
  localparam int WW    = 72;
  localparam int DEPTH = 2;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            srst;
  logic            arb_en;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    arb_grant;
  logic [N-1:0]    i_awvalid;
  logic [N-1:0]    i_awready;
  logic [N*AW-1:0] i_awch;
  logic [N-1:0]    i_wvalid;
  logic [N-1:0]    i_wready;
  logic [N-1:0]    i_wlast;
  logic [N*WW-1:0] i_wch;
  logic            o_awvalid;
  logic            o_awready;
  logic [AW-1:0]   o_awch;
  logic            o_wvalid;
  logic            o_wready;
  logic            o_wlast;
  logic [WW-1:0]   o_wch;

  always #5 aclk = ~aclk;

  axicb_slv_wr_mux #(
    .REQ_NB      (N),
    .AWCH_W      (AW),
    .WCH_W       (WW),
    .ORDER_DEPTH (DEPTH)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .arb_en    (arb_en),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .i_awvalid (i_awvalid),
    .i_awready (i_awready),
    .i_awch    (i_awch),
    .i_wvalid  (i_wvalid),
    .i_wready  (i_wready),
    .i_wlast   (i_wlast),
    .i_wch     (i_wch),
    .o_awvalid (o_awvalid),
    .o_awready (o_awready),
    .o_awch    (o_awch),
    .o_wvalid  (o_wvalid),
    .o_wready  (o_wready),
    .o_wlast   (o_wlast),
    .o_wch     (o_wch)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an AW owner (if any) plus a queue of masters owning future W bursts.
  bit m_busy;
  int m_owner;
  int m_order[$];

  logic          e_arb_en, e_awvalid, e_wvalid, e_wlast;
  logic [N-1:0]  e_awready, e_wready;
  logic [AW-1:0] e_awch;
  logic [WW-1:0] e_wch;

  typedef struct {
    logic [3:0] awv;
    logic [3:0] gnt;
    logic       awr;
    logic [3:0] wv;
    logic [3:0] wl;
    logic       wr;
    logic [7:0] wd;
    logic       x_en;
    logic       x_awv;
    logic [3:0] x_awr;
    logic       x_wv;
    logic [3:0] x_wr;
    logic       x_wl;
    logic [7:0] x_awch;
    logic [7:0] x_wch;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit act;
    int h;
    act       = aresetn && !srst;
    e_arb_en  = act && !m_busy && (i_awvalid != 0) && (m_order.size() < DEPTH) && (arb_grant != 0);
    e_awvalid = act && m_busy && i_awvalid[m_owner];
    e_awready = (act && m_busy) ? (N'(o_awready) << m_owner) : '0;
    e_awch    = i_awch[m_owner*AW +: AW];
    e_wvalid  = 1'b0;
    e_wlast   = 1'b0;
    e_wready  = '0;
    e_wch     = '0;
    if (act && m_order.size() > 0) begin
      h        = m_order[0];
      e_wvalid = i_wvalid[h];
      e_wlast  = i_wlast[h];
      e_wready = N'(o_wready) << h;
      e_wch    = i_wch[h*WW +: WW];
    end
  endtask

  task automatic model_compare();
    check("arb_req", arb_req, i_awvalid);
    check("arb_en", arb_en, e_arb_en);
    check("o_awvalid", o_awvalid, e_awvalid);
    check("i_awready", i_awready, e_awready);
    check("o_wvalid", o_wvalid, e_wvalid);
    check("i_wready", i_wready, e_wready);
    check("o_wlast", o_wlast, e_wlast);
    if (e_awvalid) check("o_awch", o_awch, e_awch);
    if (e_wvalid) check("o_wch", o_wch, e_wch);
  endtask

  task automatic model_update();
    bit pop, push;
    if (!aresetn || srst) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_order.delete();
    end else begin
      pop  = e_wvalid && o_wready && e_wlast;
      push = e_awvalid && o_awready;
      if (pop) void'(m_order.pop_front());
      if (push) begin
        m_order.push_back(m_owner);
        m_busy = 1'b0;
      end else if (e_arb_en) begin
        m_busy  = 1'b1;
        m_owner = $clog2(arb_grant);
      end
    end
  endtask

  task automatic step_a();
    @(negedge aclk);
    model_eval();
    model_compare();
  endtask

  task automatic step_b();
    @(posedge aclk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    step_a();
    step_b();
  endtask

  task automatic quiet();
    i_awvalid = '0; arb_grant = '0; i_wvalid = '0; i_wlast = '0;
    o_awready = 1'b1; o_wready = 1'b1;
  endtask

  task automatic set_payloads();
    for (int k = 0; k < N; k++) begin
      i_awch[k*AW +: AW] = 64'hA000 + 64'(k);
      i_wch[k*WW +: WW]  = 72'hB00 + 72'(k);
    end
  endtask

  initial begin
    int r, k;
    vec_t v;

    tbl[0] = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'hA0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'hA0, 1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 8'h11, 8'h00};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'hA0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h00, 8'hA0};
    tbl[5] = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'hA1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h00, 8'hA1};
    tbl[6] = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'hA2, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h00, 8'hA2};
    tbl[7] = '{4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'hA3, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 8'h00};

    aresetn = 1'b0; srst = 1'b0;
    quiet();
    i_awch = '0; i_wch = '0;
    repeat (2) @(posedge aclk);
    #1;
    m_busy = 1'b0; m_owner = 0; m_order.delete();

    // Reset held with busy inputs: everything handshake-related stays low.
    i_awvalid = 4'b1111; arb_grant = 4'b0001; i_wvalid = 4'b1111; i_wlast = 4'b1111;
    step_a();
    check("rst_arb_en", arb_en, 1'b0);
    check("rst_awvalid", o_awvalid, 1'b0);
    check("rst_awready", i_awready, 4'b0000);
    check("rst_wvalid", o_wvalid, 1'b0);
    check("rst_wready", i_wready, 4'b0000);
    step_b();
    aresetn = 1'b1;
    quiet();

    // Single master m1: zero grant, AW 0x11, three W beats.
    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      i_awvalid = v.awv; arb_grant = v.gnt; o_awready = v.awr;
      i_wvalid = v.wv; i_wlast = v.wl; o_wready = v.wr;
      i_awch = '0; i_awch[AW +: AW] = 64'h11;
      i_wch = '0; i_wch[WW +: WW] = WW'(v.wd);
      step_a();
      check($sformatf("tbl%0d_arb_en", i), arb_en, v.x_en);
      check($sformatf("tbl%0d_awvalid", i), o_awvalid, v.x_awv);
      check($sformatf("tbl%0d_awready", i), i_awready, v.x_awr);
      check($sformatf("tbl%0d_wvalid", i), o_wvalid, v.x_wv);
      check($sformatf("tbl%0d_wready", i), i_wready, v.x_wr);
      check($sformatf("tbl%0d_wlast", i), o_wlast, v.x_wl);
      if (v.x_awv) check($sformatf("tbl%0d_awch", i), o_awch, v.x_awch);
      if (v.x_wv) check($sformatf("tbl%0d_wch", i), o_wch, v.x_wch);
      step_b();
    end

    // Contention m0/m2: AW order follows grant, m2 W stalls behind m0.
    quiet(); set_payloads();
    i_awvalid = 4'b0101; arb_grant = 4'b0001; i_wvalid = 4'b0100;
    cycle();
    arb_grant = '0;
    step_a(); check("cont_awch_m0", o_awch, 64'hA000); step_b();
    i_awvalid = 4'b0100; arb_grant = 4'b0100;
    step_a(); check("cont_m2_early_stall", i_wready[2], 1'b0); step_b();
    arb_grant = '0;
    step_a(); check("cont_awch_m2", o_awch, 64'hA002); step_b();
    i_awvalid = '0; i_wvalid = 4'b0101; i_wlast = 4'b0001;
    step_a();
    check("cont_m2_stalled", i_wready[2], 1'b0);
    check("cont_m0_wch", o_wch, 72'hB00);
    step_b();
    i_wlast = 4'b0100;
    step_a(); check("cont_m2_served", i_wready, 4'b0100); step_b();

    // Order FIFO full (depth 2): third AW waits until a burst completes.
    quiet(); o_wready = 1'b0; i_wvalid = 4'b1011; i_wlast = 4'b1011;
    i_awvalid = 4'b0001; arb_grant = 4'b0001; cycle(); arb_grant = '0; cycle();
    i_awvalid = 4'b0010; arb_grant = 4'b0010; cycle(); arb_grant = '0; cycle();
    i_awvalid = 4'b1000; arb_grant = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step_a(); check("full_no_arb", arb_en, 1'b0); step_b();
    end
    o_wready = 1'b1;
    step_a(); check("full_pop_cycle_no_arb", arb_en, 1'b0); step_b();
    o_wready = 1'b0;
    step_a(); check("full_then_arb", arb_en, 1'b1); step_b();
    arb_grant = '0; cycle();
    i_awvalid = '0; o_wready = 1'b1;
    repeat (3) cycle();

    // AW backpressure: selection and payload hold, arbiter stays disabled.
    quiet(); i_awvalid = 4'b0100; arb_grant = 4'b0100; o_awready = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      step_a();
      check("bp_arb_en", arb_en, 1'b0);
      check("bp_awvalid", o_awvalid, 1'b1);
      check("bp_awch", o_awch, 64'hA002);
      step_b();
    end
    o_awready = 1'b1; cycle();
    i_awvalid = '0; i_wvalid = 4'b0100; i_wlast = 4'b0100; cycle();

    // Reset mid-burst, once by aresetn and once by srst.
    for (int vr = 0; vr < 2; vr++) begin
      quiet();
      i_awvalid = 4'b0100; arb_grant = 4'b0100; cycle();
      arb_grant = '0; cycle();
      i_awvalid = '0; i_wvalid = 4'b0100; cycle();
      if (vr == 0) aresetn = 1'b0; else srst = 1'b1;
      step_a();
      check($sformatf("rst%0d_during_wvalid", vr), o_wvalid, 1'b0);
      check($sformatf("rst%0d_during_wready", vr), i_wready, 4'b0000);
      step_b();
      aresetn = 1'b1; srst = 1'b0;
      step_a();
      check($sformatf("rst%0d_after_wvalid", vr), o_wvalid, 1'b0);
      check($sformatf("rst%0d_after_wready", vr), i_wready, 4'b0000);
      check($sformatf("rst%0d_after_awvalid", vr), o_awvalid, 1'b0);
      step_b();
      i_wvalid = '0; i_awvalid = 4'b0010; arb_grant = 4'b0010;
      step_a(); check($sformatf("rst%0d_fresh_arb", vr), arb_en, 1'b1); step_b();
      arb_grant = '0;
      step_a();
      check($sformatf("rst%0d_fresh_aw", vr), o_awvalid, 1'b1);
      check($sformatf("rst%0d_fresh_awready", vr), i_awready, 4'b0010);
      step_b();
      i_awvalid = '0; i_wvalid = 4'b0010; i_wlast = 4'b0010;
      step_a();
      check($sformatf("rst%0d_fresh_w", vr), o_wvalid, 1'b1);
      check($sformatf("rst%0d_fresh_wlast", vr), o_wlast, 1'b1);
      step_b();
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      i_awvalid = N'($urandom);
      i_wvalid  = N'($urandom);
      i_wlast   = N'($urandom & $urandom);
      o_awready = ($urandom_range(0, 3) != 0);
      o_wready  = ($urandom_range(0, 3) != 0);
      for (int m = 0; m < N; m++) begin
        i_awch[m*AW +: AW] = {$urandom, $urandom};
        i_wch[m*WW +: WW]  = WW'({$urandom, $urandom, $urandom});
      end
      r = $urandom_range(0, 9);
      if (r == 0) begin
        arb_grant = '0;
      end else if (r == 1 || i_awvalid == '0) begin
        arb_grant = N'(1) << $urandom_range(0, N-1);
      end else begin
        do k = $urandom_range(0, N-1); while (!i_awvalid[k]);
        arb_grant = N'(1) << k;
      end
      aresetn = ($urandom_range(0, 49) != 0);
      srst    = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axicb_slv_wr_mux.md
Name: axicb_slv_wr_mux

Overview:
- Write-path multiplexer at one slave port of the crossbar, directly downstream of the priority round-robin arbiter.
- Collects AW requests from REQ_NB masters, drives the arbiter req/en, and latches the one-hot grant.
- Forwards the winning AW to the slave and queues the winner's index in an order FIFO, so W beats are routed in AW order until WLAST.

Parameters:
- REQ_NB, 4, number of masters (1..4 supported).
- AWCH_W, 64, packed AW payload width per master.
- WCH_W, 72, packed W payload width per master (data+strb+user, excluding wlast).
- ORDER_DEPTH, 4, order FIFO depth, power of two, >=2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- srst  in  1  synchronous active-high soft reset; same effect as aresetn
- arb_en  out  1  arbiter enable; pulses when a grant is consumed
- arb_req  out  REQ_NB  arbiter request vector (= i_awvalid)
- arb_grant  in  REQ_NB  one-hot grant from arbiter
- i_awvalid  in  REQ_NB  per-master AW valid
- i_awready  out  REQ_NB  per-master AW ready
- i_awch  in  REQ_NB*AWCH_W  AW payloads, master k at [k*AWCH_W +: AWCH_W]
- i_wvalid  in  REQ_NB  per-master W valid
- i_wready  out  REQ_NB  per-master W ready
- i_wlast  in  REQ_NB  per-master W last
- i_wch  in  REQ_NB*WCH_W  W payloads
- o_awvalid  out  1  slave AW valid
- o_awready  in  1  slave AW ready
- o_awch  out  AWCH_W  slave AW payload
- o_wvalid  out  1  slave W valid
- o_wready  in  1  slave W ready
- o_wlast  out  1  slave W last
- o_wch  out  WCH_W  slave W payload

Behaviour:
- Reset (aresetn=0 or srst=1, sampled on aclk):
  - FSM goes to IDLE; order FIFO empties; aw_sel clears to 0.
  - All ready/valid outputs and arb_en are 0.
  - In-flight transfers are abandoned and never replayed.
- AW FSM, IDLE:
  - If |i_awvalid and the FIFO is not full and arb_grant is nonzero: latch aw_sel = one-hot-to-index(arb_grant), assert arb_en for this one cycle, go to GRANTED.
  - A zero grant keeps the FSM in IDLE with arb_en=0.
  - o_awvalid=0 in IDLE.
- AW FSM, GRANTED:
  - Drive o_awvalid = i_awvalid[aw_sel], o_awch = payload[aw_sel], i_awready[aw_sel] = o_awready; other readies are 0.
  - On handshake: push aw_sel into the FIFO and return to IDLE.
  - If the master drops awvalid (protocol violation), hold GRANTED; no timeout.
- Latency: one bubble cycle between AW handshakes. Best-case AW throughput is 1 per 2 cycles.
- The arbiter is enabled only at decision time, so the master latched in aw_sel stays stable through the AW transfer.
- W routing:
  - FIFO empty: o_wvalid=0 and all i_wready=0.
  - FIFO non-empty: w_sel = FIFO head. Drive o_wvalid = i_wvalid[w_sel], o_wch and o_wlast from w_sel, i_wready[w_sel] = o_wready.
  - Pop on o_wvalid & o_wready & o_wlast.
  - W beats for the granted master may precede its AW handshake only once the index is in the FIFO; earlier beats are stalled.
- FIFO:
  - Count is 0..ORDER_DEPTH, with pointers wrapping modulo ORDER_DEPTH.
  - Push and pop in the same cycle are legal in any state, count unchanged.
  - Push while full cannot occur, because IDLE blocks arbitration when full.
- Simultaneous events:
  - AW push and W pop of the final beat in the same cycle: both take effect.
  - A new AW decision in the same cycle as a pop from full is permitted only on the following cycle, because the full check uses the registered count.
- Output muxes are combinational from registered selectors; there is no combinational path from o_awready to arb_en.

Decomposition:
- Package axicb_pkg: clog2-based index width constant, one-hot-to-index function.
- Sub-module axicb_order_fifo: synchronous FIFO with parameters DEPTH and WIDTH=clog2(REQ_NB), flags full/empty, sync active-low reset plus srst.
- The FSM and muxes stay in the top.

Test Plan:
- Single master: REQ_NB=4; m1 sends AW 0x11 then 3 W beats (0xA0, 0xA1, 0xA2 with wlast) -> o_awch=0x11 one cycle after arb_en; FIFO holds 1; three o_w beats in order; FIFO empty after wlast.
- Contention: m0 and m2 assert AW together, arb_grant alternates 0001/0100 -> o_aw order follows grant; W from m2 stalled (i_wready[2]=0) until m0's wlast pops.
- FIFO full: ORDER_DEPTH=2, o_wready=0, three AWs queued -> third AW not arbitrated (arb_en=0) until one W burst completes; then accepted.
- Backpressure: o_awready low for 5 cycles in GRANTED -> aw_sel and o_awch stable, arb_en=0 throughout.
- Reset mid-burst: aresetn=0 after 1 of 4 W beats -> next cycle all valids/readies 0, FIFO empty, FSM IDLE; fresh AW proceeds normally. Repeat with srst=1.
- Zero grant: i_awvalid=0010, arb_grant=0000 -> FSM stays IDLE, arb_en=0, no AW forwarded.
